// File: rtl/dense_input_packer_if.sv
// Handshake and packed-output bundle between the flatten/pool stage, the packer and the dense engine.
// master drives the element stream and observes the packed word; slave is the packer itself.
`timescale 1ns/1ps
interface dense_input_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUMI_ONCE  = 36,
   parameter int NUM_CHUNK  = 3
);
   localparam int CW = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;

   logic [DATA_WIDTH-1:0]           data_i;
   logic                            valid_i;
   logic                            ready_o;
   logic [DATA_WIDTH*NUMI_ONCE-1:0] data_o;
   logic                            valid_o;
   logic [CW-1:0]                   chunk_idx_o;
   logic                            frame_done_o;

   modport master (
      output data_i, valid_i,
      input  ready_o, data_o, valid_o, chunk_idx_o, frame_done_o
   );

   modport slave (
      input  data_i, valid_i,
      output ready_o, data_o, valid_o, chunk_idx_o, frame_done_o
   );
endinterface

// File: rtl/dense_input_packer.sv
// Packs NUMI_ONCE serial elements into one wide word, pulses it for one cycle, then holds a guard gap.
// Define DENSE_PACK_DBUF_EN to add a shadow buffer that keeps accepting elements during the gap.
`timescale 1ns/1ps
module dense_input_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUMI_ONCE  = 36,
   parameter int NUM_CHUNK  = 3,
   parameter int GAP_CYCLES = 200
) (
   input logic               clk,
   input logic               rstn,
   dense_input_packer_if.slave bus
);
   localparam int CNTW = $clog2(NUMI_ONCE + 1);
   localparam int CW   = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
   localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(NUMI_ONCE - 1);
   localparam logic [CNTW-1:0] CNT_FULL   = CNTW'(NUMI_ONCE);
   localparam logic [CW-1:0]   CHUNK_LAST = CW'(NUM_CHUNK - 1);
   localparam logic [GW-1:0]   GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t                          state_reg, state_next;
   logic [CNTW-1:0]                 cnt_reg, cnt_next;
   logic [CW-1:0]                   chunk_reg, chunk_next;
   logic [GW-1:0]                   gap_reg, gap_next;
   logic                            ready_reg, ready_next;
   logic                            xfer;
   logic                            fill_we;
   logic                            buf_clear;
   logic                            send;
   logic [DATA_WIDTH*NUMI_ONCE-1:0] packed_word;

`ifdef DENSE_PACK_DBUF_EN
   logic [CNTW-1:0] sh_cnt_reg, sh_cnt_next;
   logic [CNTW-1:0] sh_total;
   logic            sh_we;
   logic            sh_load;
`endif

   assign xfer = bus.valid_i && ready_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      chunk_next = chunk_reg;
      gap_next   = gap_reg;
      ready_next = ready_reg;
      fill_we    = 1'b0;
      buf_clear  = 1'b0;
`ifdef DENSE_PACK_DBUF_EN
      sh_we       = 1'b0;
      sh_load     = 1'b0;
      sh_cnt_next = sh_cnt_reg;
      sh_total    = sh_cnt_reg + CNTW'(xfer);
`endif
      case (state_reg)
         FILL: begin
            ready_next = 1'b1;
            if (xfer) begin
               fill_we  = 1'b1;
               cnt_next = cnt_reg + CNTW'(1);
               // ready drops on the same edge that captures the last element
               if (cnt_reg == CNT_LAST) begin
                  state_next = SEND;
                  ready_next = 1'b0;
               end
            end
         end
         SEND: begin
            cnt_next   = '0;
            buf_clear  = 1'b1;
            chunk_next = (chunk_reg == CHUNK_LAST) ? '0 : chunk_reg + CW'(1);
            if (GAP_CYCLES == 0) begin
               state_next = FILL;
               ready_next = 1'b1;
            end else begin
               state_next = GAP;
`ifdef DENSE_PACK_DBUF_EN
               ready_next = 1'b1;
`else
               ready_next = 1'b0;
`endif
            end
         end
         GAP: begin
`ifdef DENSE_PACK_DBUF_EN
            if (xfer) begin
               sh_we       = 1'b1;
               sh_cnt_next = sh_total;
            end
            ready_next = (sh_total < CNT_FULL);
`endif
            if (gap_reg == GAP_LAST) begin
               gap_next = '0;
`ifdef DENSE_PACK_DBUF_EN
               // shadow (including a final-cycle transfer) becomes the primary chunk
               sh_load     = 1'b1;
               sh_cnt_next = '0;
               cnt_next    = sh_total;
               if (sh_total == CNT_FULL) begin
                  state_next = SEND;
                  ready_next = 1'b0;
               end else begin
                  state_next = FILL;
                  ready_next = 1'b1;
               end
`else
               state_next = FILL;
               ready_next = 1'b1;
`endif
            end else begin
               gap_next = gap_reg + GW'(1);
            end
         end
         default: begin
            state_next = FILL;
            ready_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= FILL;
         cnt_reg   <= '0;
         chunk_reg <= '0;
         gap_reg   <= '0;
         ready_reg <= 1'b0;
`ifdef DENSE_PACK_DBUF_EN
         sh_cnt_reg <= '0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         chunk_reg <= chunk_next;
         gap_reg   <= gap_next;
         ready_reg <= ready_next;
`ifdef DENSE_PACK_DBUF_EN
         sh_cnt_reg <= sh_cnt_next;
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < NUMI_ONCE; gi++) begin : g_slot
         logic [DATA_WIDTH-1:0] slot_reg;
`ifdef DENSE_PACK_DBUF_EN
         logic [DATA_WIDTH-1:0] sh_reg;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               sh_reg <= '0;
            end else if (sh_load) begin
               sh_reg <= '0;
            end else if (sh_we && (sh_cnt_reg == CNTW'(gi))) begin
               sh_reg <= bus.data_i;
            end
         end
`endif

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               slot_reg <= '0;
            end else if (buf_clear) begin
               slot_reg <= '0;
`ifdef DENSE_PACK_DBUF_EN
            end else if (sh_load) begin
               slot_reg <= (sh_we && (sh_cnt_reg == CNTW'(gi))) ? bus.data_i : sh_reg;
`endif
            end else if (fill_we && (cnt_reg == CNTW'(gi))) begin
               slot_reg <= bus.data_i;
            end
         end

         assign packed_word[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
      end
   endgenerate

   assign send             = (state_reg == SEND);
   assign bus.ready_o      = ready_reg;
   assign bus.valid_o      = send;
   assign bus.data_o       = send ? packed_word : '0;
   assign bus.chunk_idx_o  = send ? chunk_reg : '0;
   assign bus.frame_done_o = send && (chunk_reg == CHUNK_LAST);
endmodule

// File: tb/tb_dense_input_packer.sv
// Scoreboard bench for dense_input_packer: directed chunks queue expected words, a monitor checks each pulse.
`timescale 1ns/1ps
module tb_dense_input_packer;
   localparam int DW = 8;
   localparam int NI = 36;
   localparam int NC = 3;
   localparam int GC = 200;
   localparam int WW = DW * NI;

   typedef struct {
      logic [WW-1:0] data;
      int            chunk;
      int            fd;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   dense_input_packer_if #(.DATA_WIDTH(DW), .NUMI_ONCE(NI), .NUM_CHUNK(NC)) bus ();

   dense_input_packer #(
      .DATA_WIDTH(DW), .NUMI_ONCE(NI), .NUM_CHUNK(NC), .GAP_CYCLES(GC)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus.slave)
   );

   exp_t          sb[$];
   int            pulse_cyc[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            idle_err = 0;
   int            cyc = 0;
   logic [WW-1:0] cur_word = '0;
   int            cur_cnt = 0;
   int            model_chunk = 0;
   int            lat_chk = 1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void check_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // One element transfer; garbage is driven while ready_o is low so a stray capture corrupts data_o.
   task automatic push(input logic [7:0] d, output int waits);
      waits = 0;
      bus.valid_i = 1'b1;
      while (!bus.ready_o && waits < 1000) begin
         bus.data_i = 8'($urandom);
         @(posedge clk);
         #1;
         waits++;
      end
      if (!bus.ready_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: got ready_o=0 after %0d cycles, expected ready_o=1", waits);
      end else begin
         bus.data_i = d;
         @(posedge clk);
         #1;
         cur_word[cur_cnt*DW +: DW] = d;
         cur_cnt++;
         if (cur_cnt == NI) begin
            sb.push_back('{data: cur_word, chunk: model_chunk, fd: int'(model_chunk == NC - 1),
                           cyc: (lat_chk != 0) ? cyc : -1});
            $display("[TB] chunk %0d queued at cycle %0d", model_chunk, cyc);
            cur_word = '0;
            cur_cnt = 0;
            model_chunk = (model_chunk + 1) % NC;
         end
      end
   endtask

   task automatic wait_pulses(input int n);
      int i;
      i = 0;
      while (pulse_cyc.size() < n && i < 2000) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (pulse_cyc.size() < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL pulse_timeout: got %0d pulses, expected %0d", pulse_cyc.size(), n);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (bus.valid_o) begin
               pulse_cyc.push_back(cyc);
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_pulse: got valid_o=1 at cycle %0d, expected no pulse", cyc);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("[TB] pulse cycle %0d chunk_idx %0d frame_done %0d", cyc, bus.chunk_idx_o, bus.frame_done_o);
                  check_word("data_o", bus.data_o, e.data);
                  check("chunk_idx_o", int'(bus.chunk_idx_o), e.chunk);
                  check("frame_done_o", int'(bus.frame_done_o), e.fd);
                  if (e.cyc >= 0) check("pulse_latency", cyc, e.cyc);
               end
            end else if (bus.data_o != '0 || bus.chunk_idx_o != '0 || bus.frame_done_o) begin
               idle_err++;
            end
         end
      end
   end

   initial begin
      int w;
      int first_cap;
      bus.valid_i = 1'b0;
      bus.data_i = '0;
      rstn = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("rst_ready_o", int'(bus.ready_o), 0);
      check("rst_valid_o", int'(bus.valid_o), 0);
      check_word("rst_data_o", bus.data_o, '0);
      check("rst_chunk_idx_o", int'(bus.chunk_idx_o), 0);
      check("rst_frame_done_o", int'(bus.frame_done_o), 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("ready_before_edge", int'(bus.ready_o), 0);
      @(posedge clk);
      #1;
      check("ready_after_release", int'(bus.ready_o), 1);

      // chunk 0: the basic packing pattern
      for (int k = 0; k < NI; k++) push(8'h1C + 8'(k / 2), w);

      // chunk 1: valid_i stays high through the gap
`ifdef DENSE_PACK_DBUF_EN
      lat_chk = 0;
`endif
      first_cap = 0;
      for (int k = 0; k < NI; k++) begin
         push(8'h2C + 8'(k / 2), w);
         if (k == 0) begin
            first_cap = cyc;
`ifdef DENSE_PACK_DBUF_EN
            check("gap_wait_cycles", w, 1);
`else
            check("gap_wait_cycles", w, GC + 1);
`endif
         end
      end
      for (int k = 0; k < NI; k++) push(8'h10 + 8'(k / 2), w);
      bus.valid_i = 1'b0;
      wait_pulses(3);
      if (pulse_cyc.size() >= 3) begin
`ifdef DENSE_PACK_DBUF_EN
         check("first_capture_offset", first_cap - pulse_cyc[0], 2);
         check("pulse_spacing_0_1", pulse_cyc[1] - pulse_cyc[0], GC + 1);
         check("pulse_spacing_1_2", pulse_cyc[2] - pulse_cyc[1], GC + 1);
`else
         check("first_capture_offset", first_cap - pulse_cyc[0], GC + 2);
         check("pulse_spacing_0_1", pulse_cyc[1] - pulse_cyc[0], GC + NI + 1);
         check("pulse_spacing_1_2", pulse_cyc[2] - pulse_cyc[1], GC + NI + 1);
`endif
      end

      // chunk with valid_i toggling; distinct values expose duplicates or drops
      for (int k = 0; k < NI; k++) begin
         push(8'h40 + 8'(k), w);
         bus.valid_i = 1'b0;
         @(posedge clk);
         #1;
      end
      wait_pulses(4);

      // reset in the middle of a chunk discards it and restarts the chunk count
      for (int k = 0; k < 20; k++) push(8'h90 + 8'(k), w);
      bus.valid_i = 1'b0;
      rstn = 1'b0;
      #1;
      check("midrst_ready_o", int'(bus.ready_o), 0);
      check("midrst_valid_o", int'(bus.valid_o), 0);
      check_word("midrst_data_o", bus.data_o, '0);
      cur_word = '0;
      cur_cnt = 0;
      model_chunk = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      lat_chk = 1;
      for (int k = 0; k < NI; k++) push(8'hA0 + 8'(k), w);
      bus.valid_i = 1'b0;
      wait_pulses(5);
      repeat (5) @(posedge clk);
      #1;
      check("total_pulses", pulse_cyc.size(), 5);
      check("scoreboard_empty", sb.size(), 0);
      check("idle_outputs_zero_violations", idle_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dense_input_packer.md
Name: dense_input_packer

Overview:
- Transmit-side feeder for the dense layer input interface.
- Accepts a serial feature stream of one DATA_WIDTH element per handshake, from the flatten/pool stage.
- Packs NUMI_ONCE elements into one wide word and presents it as a single-cycle valid_o pulse, with data zero when not valid.
- Enforces a guard gap of GAP_CYCLES between chunks so the downstream dense engine can finish each partial MAC pass; a frame is NUM_CHUNK chunks.

Parameters:
DATA_WIDTH, 8, bits per feature element
NUMI_ONCE, 36, elements packed per output word
NUM_CHUNK, 3, chunks per frame (frame = NUM_CHUNK*NUMI_ONCE elements)
GAP_CYCLES, 200, idle cycles enforced after each valid_o pulse

Ports:
clk  input  1  clock, rising-edge
rstn  input  1  asynchronous active-low reset
data_i  input  DATA_WIDTH  serial feature element
valid_i  input  1  data_i valid; transfer occurs when valid_i && ready_o
ready_o  output  1  packer can accept an element this cycle
data_o  output  DATA_WIDTH*NUMI_ONCE  packed word; element k at [k*DATA_WIDTH +: DATA_WIDTH]
valid_o  output  1  one-cycle pulse marking data_o valid
chunk_idx_o  output  max(1,$clog2(NUM_CHUNK))  index of chunk on data_o, qualified by valid_o
frame_done_o  output  1  pulses with valid_o on chunk NUM_CHUNK-1

Behaviour:
- Reset (async assert, sync release): all outputs 0; internal state as follows.
  - State FILL; element count 0, chunk count 0, gap counter 0.
  - Buffers zeroed.
  - ready_o goes to 1 on the first clock edge after release.
- FSM states FILL, SEND, GAP.
- FILL:
  - ready_o=1.
  - Each transfer writes data_i to slot cnt, then cnt++.
  - The transfer with cnt==NUMI_ONCE-1 moves the FSM to SEND; ready_o drops in that same edge.
  - valid_i without ready_o is ignored; data is not captured.
- SEND (one cycle):
  - valid_o=1, data_o=packed buffer, chunk_idx_o=chunk count.
  - frame_done_o=1 iff chunk count==NUM_CHUNK-1.
  - Next edge: chunk count increments, wrapping to 0 after NUM_CHUNK-1; cnt clears; buffer clears; go to GAP.
- Latency: valid_o is high the cycle after the edge that captured the last element.
- GAP:
  - ready_o=0 (base build); counter runs for GAP_CYCLES cycles, then FILL.
  - GAP_CYCLES==0 goes straight from SEND to FILL.
  - Minimum pulse-to-pulse period is GAP_CYCLES+NUMI_ONCE+1 cycles.
- Outside SEND: data_o is all zero, and valid_o, frame_done_o and chunk_idx_o are 0.
- Width rule: data is passed through unmodified (no arithmetic); slot index is NUMI_ONCE-wrapped.
- Reset mid-fill or mid-gap: partial chunk discarded, chunk count returns to 0, no valid_o emitted.

Optional Feature:
Macro DENSE_PACK_DBUF_EN.
- Defined:
  - A shadow buffer with its own count accepts elements during GAP; ready_o=1 in GAP while shadow count<NUMI_ONCE.
  - At GAP end, shadow contents and count transfer to the primary; the shadow clears.
  - If the transferred count==NUMI_ONCE, the FSM goes to SEND in the next cycle, so the period can shrink to GAP_CYCLES+1.
  - A transfer on the final GAP cycle lands in the shadow before the move.
- Undefined: no shadow buffer; ready_o=0 throughout GAP.

Test Plan:
1. Reset held 50 cycles, then stream elements 8'h1C+k/2 (k=0..35) with continuous valid_i → ready_o high from first cycle after release; single valid_o one cycle after 36th transfer; data_o slot k=8'h1C+k/2; chunk_idx_o=0; frame_done_o=0.
2. Three chunks with bases 8'h1C, 8'h2C, 8'h10 → three pulses, chunk_idx_o 0,1,2; frame_done_o only on third; pulse spacing exactly 237 cycles (base build, valid_i always high).
3. valid_i toggling every other cycle during FILL → all 36 elements captured in order; no duplicates; valid_o one cycle after last accepted element.
4. valid_i held high during GAP (base build) → ready_o=0 for 200 cycles, no capture; first element captured on the cycle ready_o rises.
5. rstn pulsed low after 20 elements of chunk 1 → all outputs 0 immediately; the next full 36-element chunk emits with chunk_idx_o=0 and only the new data.
6. DENSE_PACK_DBUF_EN defined, continuous stream → shadow fills during GAP; second valid_o exactly 201 cycles after the first; data_o holds elements 36..71 in order.
